instr_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction memories (instr_mem_1byte/2byte/4byte); owns the PC and drives r_addr_imem.
- Captures r_data_imem into a small instruction queue and presents {pc, instr} to decode over a valid/ready handshake.
- Supports redirect (branch/jump) with queue flush, and a fetch-enable gate.

---
 rtl/instr_fetch_unit_if.sv | 41 ++++
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory read port, redirect, fetch gate and decode handshake.
interface instr_fetch_unit_if #(
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned DATA_W = 32
);
    logic              fetch_en;
    logic [ADDR_W-1:0] r_addr_imem;
    logic [DATA_W-1:0] r_data_imem;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_instr;
    logic [ADDR_W-1:0] out_pc;

    // Fetch unit side
    modport master (
        input  fetch_en,
        output r_addr_imem,
        input  r_data_imem,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc
    );

    // Environment side: memory, branch unit and decode
    modport slave (
        output fetch_en,
        input  r_addr_imem,
        output r_data_imem,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, reads combinational instruction memory,
// buffers {pc, instr} in a small queue and hands it to decode over valid/ready.
module instr_fetch_unit #(
    parameter int unsigned ADDR_W      = 7,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned QUEUE_DEPTH = 2
) (
    input logic                  clk,
    input logic                  rst,
    instr_fetch_unit_if.master   bus
);
    localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
    localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(QUEUE_DEPTH);
    localparam logic [ADDR_W-1:0] RST_PC_C = ADDR_W'(RESET_PC);

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [DATA_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    entry_t            queue_q [QUEUE_DEPTH];
    entry_t            queue_d [QUEUE_DEPTH];

    logic head_valid_c;
    logic deq_c;
    logic enq_c;
    logic unused_redirect_lsb;

    // Low target bits are forced to zero, so they never reach the PC
    assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

    // Handshake qualifiers for this cycle
    assign head_valid_c = (count_q != '0);
    assign deq_c        = head_valid_c & bus.out_ready;
    assign enq_c        = bus.fetch_en & ~bus.redirect_valid & ((count_q < DEPTH_C) | deq_c);

    // Next-state: redirect flushes and retargets, otherwise push/pop the queue
    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        queue_d  = queue_q;

        if (bus.redirect_valid) begin
            pc_d     = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq_c) begin
                queue_d[wr_ptr_q] = '{pc: pc_q, instr: bus.r_data_imem};
                wr_ptr_d          = wr_ptr_q + PTR_W'(1);
                pc_d              = pc_q + ADDR_W'(4);
            end
            if (deq_c) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(enq_c) - CNT_W'(deq_c);
        end
    end

    // State registers; queue payload needs no reset since count gates it
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RST_PC_C;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Queue storage
    always_ff @(posedge clk) begin
        queue_q <= queue_d;
    end

    // Outputs come straight from flops; empty queue presents zeros
    assign bus.r_addr_imem = pc_q;
    assign bus.out_valid   = head_valid_c;
    assign bus.out_pc      = head_valid_c ? queue_q[rd_ptr_q].pc    : '0;
    assign bus.out_instr   = head_valid_c ? queue_q[rd_ptr_q].instr : '0;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a combinational memory model word(a) = 32'h1000_0000 | a.
module tb_instr_fetch_unit;
    logic clk;
    logic rst;
    int   errors;
    int   checks;

    instr_fetch_unit_if #(.ADDR_W(7), .DATA_W(32)) bus ();

    instr_fetch_unit #(
        .ADDR_W(7), .DATA_W(32), .RESET_PC(0), .QUEUE_DEPTH(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    assign bus.r_data_imem = 32'h1000_0000 | 32'(bus.r_addr_imem);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [6:0] pc);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, ".pc"},    32'(bus.out_pc),    32'(pc));
        check({tag, ".instr"}, bus.out_instr, v ? (32'h1000_0000 | 32'(pc)) : 32'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.fetch_en       = 1'b1;
        bus.out_ready      = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 7'h00;

        // Reset state
        step();
        check_out("reset", 1'b0, 7'h00);
        check("reset.addr", 32'(bus.r_addr_imem), 32'h00);

        // Streaming: first instruction one edge after reset release, then no bubbles
        rst = 1'b0;
        step();
        check_out("stream0", 1'b1, 7'h00);
        check("stream0.addr", 32'(bus.r_addr_imem), 32'h04);
        step(); check_out("stream4", 1'b1, 7'h04);
        step(); check_out("stream8", 1'b1, 7'h08);
        step(); check_out("stream12", 1'b1, 7'h0C);

        // Backpressure from reset: queue fills with pc 0 and 4, PC holds at 8
        rst = 1'b1;
        bus.out_ready = 1'b0;
        step();
        rst = 1'b0;
        step(); check_out("bp.fill1", 1'b1, 7'h00);
        step(); check_out("bp.fill2", 1'b1, 7'h00);
        check("bp.addr_full", 32'(bus.r_addr_imem), 32'h08);
        step(); check_out("bp.hold", 1'b1, 7'h00);
        check("bp.addr_hold", 32'(bus.r_addr_imem), 32'h08);
        bus.out_ready = 1'b1;
        step(); check_out("bp.drain4", 1'b1, 7'h04);
        check("bp.addr12", 32'(bus.r_addr_imem), 32'h0C);
        step(); check_out("bp.drain8", 1'b1, 7'h08);

        // Redirect to 7'h23 mid-stream: aligned to 7'h20, one bubble, no stale PCs
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 7'h23;
        step();
        bus.redirect_valid = 1'b0;
        check("redir.addr", 32'(bus.r_addr_imem), 32'h20);
        check_out("redir.bubble", 1'b0, 7'h00);
        step(); check_out("redir.t0", 1'b1, 7'h20);
        step(); check_out("redir.t1", 1'b1, 7'h24);

        // Redirect near top of address space: PC wraps 7'h7C -> 7'h00
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 7'h78;
        step();
        bus.redirect_valid = 1'b0;
        check("wrap.addr", 32'(bus.r_addr_imem), 32'h78);
        check_out("wrap.bubble", 1'b0, 7'h00);
        step(); check_out("wrap.78", 1'b1, 7'h78);
        step(); check_out("wrap.7c", 1'b1, 7'h7C);
        step(); check_out("wrap.00", 1'b1, 7'h00);
        step(); check_out("wrap.04", 1'b1, 7'h04);

        // Fill to full, then simultaneous enq+deq keeps it full
        bus.out_ready = 1'b0;
        step(); check_out("full.fill", 1'b1, 7'h04);
        step(); check_out("full.hold", 1'b1, 7'h04);
        check("full.addr", 32'(bus.r_addr_imem), 32'h0C);
        bus.out_ready = 1'b1;
        step(); check_out("full.ed1", 1'b1, 7'h08);
        check("full.ed1.addr", 32'(bus.r_addr_imem), 32'h10);
        step(); check_out("full.ed2", 1'b1, 7'h0C);
        check("full.ed2.addr", 32'(bus.r_addr_imem), 32'h14);

        // fetch_en low: two-entry queue drains in two cycles, PC frozen
        bus.fetch_en = 1'b0;
        step(); check_out("drain1", 1'b1, 7'h10);
        step(); check_out("drain2", 1'b0, 7'h00);
        check("drain.addr", 32'(bus.r_addr_imem), 32'h14);
        step(); check_out("drain.idle", 1'b0, 7'h00);
        check("drain.addr_frozen", 32'(bus.r_addr_imem), 32'h14);

        // Reset mid-stream with a full queue and redirect asserted
        bus.fetch_en  = 1'b1;
        bus.out_ready = 1'b0;
        step(); step();
        check_out("prerst.full", 1'b1, 7'h14);
        rst = 1'b1;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 7'h40;
        step();
        rst = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.out_ready      = 1'b1;
        check_out("midrst", 1'b0, 7'h00);
        check("midrst.addr", 32'(bus.r_addr_imem), 32'h00);
        step(); check_out("restart0", 1'b1, 7'h00);
        step(); check_out("restart4", 1'b1, 7'h04);

        // Back-to-back redirects: last one wins, nothing enqueued in between
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 7'h10;
        step();
        check_out("b2b.first", 1'b0, 7'h00);
        bus.redirect_pc = 7'h56;
        step();
        bus.redirect_valid = 1'b0;
        check_out("b2b.second", 1'b0, 7'h00);
        check("b2b.addr", 32'(bus.r_addr_imem), 32'h54);
        step(); check_out("b2b.t0", 1'b1, 7'h54);
        step(); check_out("b2b.t1", 1'b1, 7'h58);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
